led_arbiter: RTL



---
 rtl/led_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - fixed-priority RGB LED arbiter with minimum hold time
//
// Shares one RGB LED between three requesters. req[2] has the highest
// priority and req[0] the lowest. A new owner is protected from preemption
// by higher-priority requesters for MIN_HOLD cycles after its grant edge.
// An owner that drops its request is released at the next edge. Grant and
// LED drive are registered and update on the same edge, so the LED never
// shows a colour that belongs to a requester other than the current owner.
//
// Optional feature macro: LED_ARB_BLINK_EN
//   Defined:   while requester 2 owns the LED, its colour blinks with
//              BLINK_HALF cycles on and BLINK_HALF cycles off.
//   Undefined: every owner is shown steadily and BLINK_HALF is unused.
//
// Parameters:
//   MIN_HOLD    cycles an owner is protected after its grant (>= 1)
//   BLINK_HALF  half-period of the alert blink in cycles (>= 1)
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                synchronous active-low reset
//   req[2:0]             per-requester request, [2] highest priority
//   color0/1/2[2:0]      {red,green,blue} wanted by each requester
//   grant[2:0]           one-hot owner, 3'b000 when idle
//   red, green, blue     registered LED drive

module led_arbiter #(
    parameter int MIN_HOLD   = 2000000,
    parameter int BLINK_HALF = 6000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] color0,
    input  logic [2:0] color1,
    input  logic [2:0] color2,
    output logic [2:0] grant,
    output logic       red,
    output logic       green,
    output logic       blue
);

    localparam int HW = $clog2(MIN_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_grant;
    logic [2:0]    w_grant_nxt;
    logic [2:0]    r_rgb;
    logic [2:0]    w_rgb_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic [2:0]    w_higher;

`ifdef LED_ARB_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0] r_blink_cnt;
    logic [BW-1:0] w_blink_cnt_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
`endif

    function automatic logic [2:0] f_highest(input logic [2:0] r);
        if (r[2])      return 3'b100;
        else if (r[1]) return 3'b010;
        else if (r[0]) return 3'b001;
        else           return 3'b000;
    endfunction

    function automatic logic [2:0] f_color(input logic [2:0] g,
                                           input logic [2:0] c0,
                                           input logic [2:0] c1,
                                           input logic [2:0] c2);
        case (g)
            3'b001:  return c0;
            3'b010:  return c1;
            3'b100:  return c2;
            default: return 3'b000;
        endcase
    endfunction

    // Requests strictly above the current owner; only these may preempt.
    always_comb begin
        case (r_grant)
            3'b001:  w_higher = req & 3'b110;
            3'b010:  w_higher = req & 3'b100;
            default: w_higher = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_nxt = f_highest(req);
                    w_state_nxt = S_OWN;
                end
            end
            S_OWN: begin
                if ((req & r_grant) == 3'b000) begin
                    // Owner released: hand straight to the best remaining
                    // requester so there is no idle gap in between.
                    w_grant_nxt = f_highest(req);
                    w_state_nxt = (|req) ? S_OWN : S_IDLE;
                end else if ((|w_higher) && (r_hold == HOLD_MAX)) begin
                    w_grant_nxt = f_highest(w_higher);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 3'b000;
            end
        endcase

        if (w_grant_nxt != r_grant)
            w_hold_nxt = '0;
        else if ((r_state == S_OWN) && (r_hold != HOLD_MAX))
            w_hold_nxt = r_hold + HW'(1);

        w_rgb_nxt = f_color(w_grant_nxt, color0, color1, color2);

`ifdef LED_ARB_BLINK_EN
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        if (w_grant_nxt[2]) begin
            if (!r_grant[2]) begin
                // Fresh grant to the alert source always starts lit.
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = 1'b1;
            end else if (r_blink_cnt == BLINK_MAX) begin
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = ~r_phase;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BW'(1);
            end
            if (!w_phase_nxt)
                w_rgb_nxt = 3'b000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_rgb   <= 3'b000;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_rgb   <= w_rgb_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

`ifdef LED_ARB_BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end
`endif

    assign grant = r_grant;
    assign red   = r_rgb[2];
    assign green = r_rgb[1];
    assign blue  = r_rgb[0];

endmodule
